// File: rtl/bus_trace_if.sv
// CPU bus as observed by the trace display: strobe plus address/data/direction.
interface bus_trace_if;
  logic        cpu_strobe;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic [7:0]  data_in;
  logic        we;

  modport master (output cpu_strobe, addr, data_out, data_in, we);
  modport slave  (input  cpu_strobe, addr, data_out, data_in, we);
endinterface

// File: rtl/bus_trace_display.sv
// Captures each single-stepped 6502 bus cycle and shows address, data and a
// cycle count on an 8-digit multiplexed 7-segment display plus 4 status LEDs.
module bus_trace_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  bus_trace_if.slave      bus,
  output logic [7:0]      seg_sel,
  output logic [7:0]      seg_data,
  output logic [3:0]      led
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  cnt;
  } trace_t;

  trace_t          shadow_q, shadow_d;
  trace_t          disp_q, disp_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      idx_q, idx_d;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            toggle_q, toggle_d;
  logic            presc_wrap;
  logic            frame_load;
  logic            blank;
  logic            dp_n;
  logic [3:0]      nibble;
  logic [7:0]      seg_sel_d, seg_data_d;
  logic [3:0]      led_d;

  // Active-low hex font for segments g..a.
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  // Next-state for capture, scan timing and frame-synchronous display load;
  // outputs are derived from next state so seg_sel and seg_data stay aligned.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    toggle_d  = toggle_q;

    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    frame_load = presc_wrap && (idx_q == 3'd7);
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = presc_wrap ? idx_q + 3'd1 : idx_q;

    // Display takes the pre-strobe shadow when a strobe coincides with the load.
    disp_d = frame_load ? shadow_q : disp_q;

    if (bus.cpu_strobe) begin
      shadow_d.addr = bus.addr;
      shadow_d.data = bus.we ? bus.data_out : bus.data_in;
      shadow_d.we   = bus.we;
      shadow_d.cnt  = shadow_q.cnt + 8'd1;
      toggle_d      = ~toggle_q;
      pending_d     = 1'b1;
      if (pending_q && !frame_load) overrun_d = 1'b1;
    end else if (frame_load) begin
      pending_d = 1'b0;
    end

    case (idx_d)
      3'd7:    nibble = disp_d.addr[15:12];
      3'd6:    nibble = disp_d.addr[11:8];
      3'd5:    nibble = disp_d.addr[7:4];
      3'd4:    nibble = disp_d.addr[3:0];
      3'd3:    nibble = disp_d.data[7:4];
      3'd2:    nibble = disp_d.data[3:0];
      3'd1:    nibble = disp_d.cnt[7:4];
      default: nibble = disp_d.cnt[3:0];
    endcase

    blank      = (presc_d < PW'(BLANK_CYCLES));
    dp_n       = !((idx_d == 3'd2) && disp_d.we);
    seg_sel_d  = blank ? 8'hFF : ~(8'd1 << idx_d);
    seg_data_d = blank ? 8'hFF : {dp_n, hex_font(nibble)};
    led_d      = {pending_d, overrun_d, toggle_d, disp_d.we};
  end

  // State and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      disp_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      toggle_q  <= 1'b0;
      seg_sel   <= 8'hFF;
      seg_data  <= 8'hFF;
      led       <= 4'h0;
    end else begin
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      toggle_q  <= toggle_d;
      seg_sel   <= seg_sel_d;
      seg_data  <= seg_data_d;
      led       <= led_d;
    end
  end

endmodule

// File: tb/tb_bus_trace_display.sv
// Bench for bus_trace_display: reference model driven by elapsed-time
// arithmetic, a capture/display vector table and hand-written corner cases.
module tb_bus_trace_display;

  localparam int SD    = 4;
  localparam int BLANK = 1;
  localparam int FRAME = 8 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg_sel, seg_data;
  logic [3:0] led;

  bus_trace_if bif ();

  bus_trace_display #(.SCAN_DIV(SD), .BLANK_CYCLES(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bif),
    .seg_sel  (seg_sel),
    .seg_data (seg_data),
    .led      (led)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference model: scan position follows from clocks elapsed since reset.
  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        w;
    logic [7:0]  c;
  } rec_t;

  rec_t m_sh, m_disp;
  logic m_pend, m_ovr, m_tog;
  int   tick;
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh = '0; m_disp = '0; m_pend = 0; m_ovr = 0; m_tog = 0; tick = 0;
    end else begin
      logic fl;
      fl = (tick % FRAME) == FRAME - 1;
      if (fl) m_disp = m_sh;
      if (bif.cpu_strobe) begin
        if (m_pend && !fl) m_ovr = 1;
        m_sh = '{a: bif.addr, d: (bif.we ? bif.data_out : bif.data_in), w: bif.we, c: m_sh.c + 8'd1};
        m_tog = ~m_tog;
        m_pend = 1;
      end else if (fl) begin
        m_pend = 0;
      end
      tick++;
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    int p, ix;
    logic [7:0] es, ed;
    logic [31:0] word;
    p  = tick % SD;
    ix = (tick / SD) % 8;
    es = (p < BLANK) ? 8'hFF : ~(8'h01 << ix);
    word = {m_disp.a, m_disp.d, m_disp.c};
    ed = font[4'(word >> (4 * ix))];
    if (ix == 2 && m_disp.w) ed[7] = 1'b0;
    check("seg_sel", 32'(seg_sel), 32'(es));
    if (es != 8'hFF) check("seg_data", 32'(seg_data), 32'(ed));
    check("led", 32'(led), 32'({m_pend, m_ovr, m_tog, m_disp.w}));
  end

  // Inputs change 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    bif.cpu_strobe = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [15:0] a, input logic [7:0] dout, input logic [7:0] din, input logic w);
    step();
    if ((tick % FRAME) == FRAME - 1) step();
    bif.addr = a; bif.data_out = dout; bif.data_in = din; bif.we = w;
    bif.cpu_strobe = 1'b1;
    step();
    bif.cpu_strobe = 1'b0;
  endtask

  task automatic wait_frame_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((tick % FRAME) != 0 && n < 3 * FRAME);
    if ((tick % FRAME) != 0) begin
      n_tests++; n_fail++;
      $display("FAIL frame_wait timeout tick=%0d", tick);
    end
  endtask

  // Called on the first falling edge of a frame; collects each lit digit.
  task automatic read_frame(output logic [7:0][7:0] dig);
    dig = '1;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if ((tick % SD) == BLANK) dig[(tick / SD) % 8] = seg_data;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        w;
    logic [63:0] dig;
    logic [3:0]  led;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [7:0][7:0] dig;
    logic [63:0] ed;

    tbl[0] = '{16'hFFFC, 8'h00, 8'h5A, 1'b0, 64'h8E8E8EC6_9288C0F9, 4'b0010};
    tbl[1] = '{16'h0200, 8'hA5, 8'h00, 1'b1, 64'hC0A4C0C0_8812C0A4, 4'b0001};
    tbl[2] = '{16'h1234, 8'h00, 8'h9E, 1'b0, 64'hF9A4B099_9086C0B0, 4'b0010};
    tbl[3] = '{16'hBDEF, 8'h78, 8'h33, 1'b1, 64'h83A1868E_F800C099, 4'b0001};
    tbl[4] = '{16'h6780, 8'hFF, 8'hC1, 1'b0, 64'h82F880C0_C6F9C092, 4'b0010};

    bif.cpu_strobe = 1'b0; bif.addr = '0; bif.data_out = '0; bif.data_in = '0; bif.we = 1'b0;

    // Reset state and first lit digit after release.
    repeat (3) @(negedge clk);
    check("rst_seg_sel", 32'(seg_sel), 32'hFF);
    check("rst_seg_data", 32'(seg_data), 32'hFF);
    check("rst_led", 32'(led), 32'h0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_blank", 32'(seg_sel), 32'hFF);
    @(negedge clk);
    check("rel_sel0", 32'(seg_sel), 32'hFE);
    check("rel_data0", 32'(seg_data), 32'hC0);

    // Table: one capture per frame, compare every digit and the LEDs.
    for (int v = 0; v < 5; v++) begin
      pulse(tbl[v].a, tbl[v].dout, tbl[v].din, tbl[v].w);
      wait_frame_start();
      check($sformatf("tbl%0d_led", v), 32'(led), 32'(tbl[v].led));
      read_frame(dig);
      ed = tbl[v].dig;
      for (int i = 0; i < 8; i++)
        check($sformatf("tbl%0d_dig%0d", v, i), 32'(dig[i]), 32'(ed[8*i +: 8]));
    end

    // Overrun: two captures in one frame, sticky across frames.
    do_reset();
    pulse(16'hAAAA, 8'h00, 8'h11, 1'b0);
    pulse(16'hBBBB, 8'h22, 8'h00, 1'b1);
    wait_frame_start();
    check("ovr_led2", 32'(led[2]), 32'h1);
    read_frame(dig);
    check("ovr_dig7", 32'(dig[7]), 32'h83);
    check("ovr_dig0", 32'(dig[0]), 32'hA4);
    wait_frame_start();
    check("ovr_sticky", 32'(led[2]), 32'h1);
    read_frame(dig);

    // Strobe on the exact frame-load edge.
    do_reset();
    pulse(16'h1111, 8'h00, 8'h11, 1'b0);
    wait_frame_start();
    for (int n = 0; n < 2 * FRAME && (tick % FRAME) != FRAME - 1; n++) step();
    bif.addr = 16'h2222; bif.data_in = 8'h22; bif.we = 1'b0;
    bif.cpu_strobe = 1'b1;
    step();
    bif.cpu_strobe = 1'b0;
    @(negedge clk);
    check("sim_pending", 32'(led[3]), 32'h1);
    check("sim_overrun", 32'(led[2]), 32'h0);
    read_frame(dig);
    check("sim_old_dig7", 32'(dig[7]), 32'hF9);
    wait_frame_start();
    check("sim_next_pending", 32'(led[3]), 32'h0);
    read_frame(dig);
    check("sim_new_dig7", 32'(dig[7]), 32'hA4);
    check("sim_new_cnt", 32'(dig[0]), 32'hA4);

    // Cycle counter wraps after 256 captures.
    do_reset();
    for (int n = 0; n < 256; n++)
      pulse(16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    wait_frame_start();
    read_frame(dig);
    check("wrap_cnt_hi", 32'(dig[1]), 32'hC0);
    check("wrap_cnt_lo", 32'(dig[0]), 32'hC0);

    // Random bus traffic with a mid-frame reset.
    for (int k = 0; k < 600; k++) begin
      step();
      bif.addr = 16'($urandom); bif.data_out = 8'($urandom);
      bif.data_in = 8'($urandom); bif.we = 1'($urandom);
      bif.cpu_strobe = ($urandom_range(5) == 0);
      if (k == 301) rst_n = 1'b0;
      if (k == 304) rst_n = 1'b1;
    end
    step();
    bif.cpu_strobe = 1'b0;
    repeat (2 * FRAME) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
